// File: rtl/text_console_writer.sv
// Character-stream to text-RAM writer: places printable codes at the cursor and
// handles CR/LF/BS/FF, clearing rows (or the whole screen) with the blank character.
module text_console_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic [7:0]  attr,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_data,
  output logic        ram_we,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, CLR_ROW, CLR_ALL} state_t;

  localparam logic [11:0] COLS_W = 12'(COLS);
  localparam logic [11:0] TOTAL  = 12'(COLS * ROWS);

  state_t      state;
  logic [11:0] clr_cnt;
  logic        wrap_pend;
  logic [11:0] row_base;
  logic [11:0] cur_addr;
  logic [4:0]  row_next;
  logic        last_col;
  logic        printable;

  assign row_base  = 12'(cursor_row) * COLS_W;
  assign cur_addr  = row_base + {5'd0, cursor_col};
  assign row_next  = (cursor_row == 5'(ROWS - 1)) ? 5'd0 : cursor_row + 5'd1;
  assign last_col  = (cursor_col == 7'(COLS - 1));
  assign printable = (ch_data >= 8'h20) && (ch_data <= 8'h7E);

  // Cursor moves at transfer time; WRITE only presents the single RAM strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLR_ALL;
      clr_cnt    <= '0;
      wrap_pend  <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      ch_ready   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (ch_valid && ch_ready) begin
            if (printable) begin
              state    <= WRITE;
              ch_ready <= 1'b0;
              busy     <= 1'b1;
              ram_we   <= 1'b1;
              ram_addr <= cur_addr;
              ram_data <= {attr, ch_data};
              if (last_col) begin
                cursor_col <= '0;
                cursor_row <= row_next;
                wrap_pend  <= 1'b1;
              end else begin
                cursor_col <= cursor_col + 7'd1;
                wrap_pend  <= 1'b0;
              end
            end else begin
              case (ch_data)
                8'h0A: begin
                  cursor_col <= '0;
                  cursor_row <= row_next;
                  clr_cnt    <= '0;
                  state      <= CLR_ROW;
                  ch_ready   <= 1'b0;
                  busy       <= 1'b1;
                end
                8'h0D: cursor_col <= '0;
                8'h08: begin
                  if (cursor_col != 7'd0) begin
                    cursor_col <= cursor_col - 7'd1;
                    wrap_pend  <= 1'b0;
                    state      <= WRITE;
                    ch_ready   <= 1'b0;
                    busy       <= 1'b1;
                    ram_we     <= 1'b1;
                    ram_addr   <= cur_addr - 12'd1;
                    ram_data   <= {attr, BLANK};
                  end
                end
                8'h0C: begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  clr_cnt    <= '0;
                  state      <= CLR_ALL;
                  ch_ready   <= 1'b0;
                  busy       <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        WRITE: begin
          clr_cnt <= '0;
          if (wrap_pend) begin
            state <= CLR_ROW;
          end else begin
            state    <= IDLE;
            ch_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        CLR_ROW: begin
          if (clr_cnt < COLS_W) begin
            ram_we   <= 1'b1;
            ram_addr <= row_base + clr_cnt;
            ram_data <= {attr, BLANK};
            clr_cnt  <= clr_cnt + 12'd1;
          end else begin
            state    <= IDLE;
            ch_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        CLR_ALL: begin
          if (clr_cnt < TOTAL) begin
            ram_we   <= 1'b1;
            ram_addr <= clr_cnt;
            ram_data <= {attr, BLANK};
            clr_cnt  <= clr_cnt + 12'd1;
          end else begin
            state    <= IDLE;
            ch_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ch_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: expected RAM writes are queued as
// characters are issued; a negedge monitor pops and compares every ram_we cycle.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic [7:0]  attr = 8'h07;
  logic [11:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .attr       (attr),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_writes = 0;
  logic [11:0] last_addr = '0;
  logic [27:0] exp_q[$];
  int          mcol = 0;
  int          mrow = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && ram_we) begin
      logic [27:0] e;
      n_writes++;
      last_addr = ram_addr;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, no write required", ram_addr, ram_data);
      end else begin
        e = exp_q.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          n_err++;
          $display("FAIL ram_write: got addr=%0d data=%h required addr=%0d data=%h",
                   ram_addr, ram_data, e[27:16], e[15:0]);
        end
      end
    end
  end

  task automatic push_w(input int addr, input logic [15:0] data);
    exp_q.push_back({12'(addr), data});
  endtask

  task automatic push_clear_row(input int r);
    for (int c = 0; c < 80; c++) push_w(r * 80 + c, {attr, 8'h20});
  endtask

  task automatic push_clear_all();
    for (int a = 0; a < 2400; a++) push_w(a, {attr, 8'h20});
  endtask

  task automatic model(input logic [7:0] code);
    if (code >= 8'h20 && code <= 8'h7E) begin
      push_w(mrow * 80 + mcol, {attr, code});
      if (mcol == 79) begin
        mcol = 0;
        mrow = (mrow == 29) ? 0 : mrow + 1;
        push_clear_row(mrow);
      end else mcol++;
    end else if (code == 8'h0A) begin
      mcol = 0;
      mrow = (mrow == 29) ? 0 : mrow + 1;
      push_clear_row(mrow);
    end else if (code == 8'h0D) begin
      mcol = 0;
    end else if (code == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push_w(mrow * 80 + mcol, {attr, 8'h20});
      end
    end else if (code == 8'h0C) begin
      push_clear_all();
      mcol = 0;
      mrow = 0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ch_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ch_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: ch_ready=0 required 1");
    end
  endtask

  // Returns #1 after the transfer edge.
  task automatic send(input logic [7:0] code);
    model(code);
    wait_ready();
    ch_data  = code;
    ch_valid = 1'b1;
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] code);
    send(code);
    wait_ready();
  endtask

  task automatic chk_cursor(input string name, input int col, input int row);
    chk({name, "_col"}, 32'(cursor_col), 32'(col));
    chk({name, "_row"}, 32'(cursor_row), 32'(row));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_data", 32'(ram_data), 0);
    chk_cursor("rst_cursor", 0, 0);
    chk("rst_ch_ready", 32'(ch_ready), 0);
    chk("rst_busy", 32'(busy), 1);

    // Power-up clear with attr 0x07
    attr = 8'h07;
    push_clear_all();
    rst = 1'b1;
    @(negedge clk);
    chk("first_clear_we", 32'(ram_we), 1);
    chk("first_clear_addr", 32'(ram_addr), 0);
    wait_ready();
    chk("init_queue_empty", 32'(exp_q.size()), 0);
    chk("init_writes", 32'(n_writes), 2400);
    chk("init_last_addr", 32'(last_addr), 2399);
    chk_cursor("init_cursor", 0, 0);
    chk("init_busy", 32'(busy), 0);

    // 'A' at (0,0), attr 0x1E
    attr = 8'h1E;
    send(8'h41);
    chk("a_we", 32'(ram_we), 1);
    chk("a_addr", 32'(ram_addr), 0);
    chk("a_data", 32'(ram_data), 32'h1E41);
    chk("a_ready_low", 32'(ch_ready), 0);
    chk("a_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    chk("a_ready_back", 32'(ch_ready), 1);
    chk("a_we_low", 32'(ram_we), 0);
    chk_cursor("a_cursor", 1, 0);

    // Column wrap from (79,5)
    for (int i = 0; i < 5; i++) send_w(8'h0A);
    for (int i = 0; i < 79; i++) send_w(8'h2E);
    chk_cursor("pre_z_cursor", 79, 5);
    attr = 8'h2A;
    send(8'h5A);
    chk("z_addr", 32'(ram_addr), 479);
    chk("z_data", 32'(ram_data), 32'h2A5A);
    wait_ready();
    chk_cursor("z_cursor", 0, 6);
    chk("z_clear_last", 32'(last_addr), 559);
    chk("z_queue_empty", 32'(exp_q.size()), 0);

    // Row wrap from (10,29), then CR
    for (int i = 0; i < 23; i++) send_w(8'h0A);
    for (int i = 0; i < 10; i++) send_w(8'h2E);
    chk_cursor("pre_lf_cursor", 10, 29);
    send_w(8'h0A);
    chk_cursor("lf_wrap_cursor", 0, 0);
    chk("lf_wrap_last", 32'(last_addr), 79);
    for (int i = 0; i < 3; i++) send_w(8'h2E);
    w0 = n_writes;
    send_w(8'h0D);
    chk_cursor("cr_cursor", 0, 0);
    chk("cr_no_write", 32'(n_writes), 32'(w0));

    // Backspace and ignored codes
    attr = 8'h4C;
    send_w(8'h0A);
    send_w(8'h0A);
    for (int i = 0; i < 5; i++) send_w(8'h2E);
    chk_cursor("pre_bs_cursor", 5, 2);
    w0 = n_writes;
    send_w(8'h08);
    chk_cursor("bs_cursor", 4, 2);
    chk("bs_one_write", 32'(n_writes), 32'(w0 + 1));
    chk("bs_addr", 32'(last_addr), 164);
    send_w(8'h0D);
    w0 = n_writes;
    send_w(8'h08);
    chk_cursor("bs_col0_cursor", 0, 2);
    send_w(8'h01);
    send_w(8'h7F);
    send_w(8'hFF);
    chk_cursor("other_cursor", 0, 2);
    chk("other_no_write", 32'(n_writes), 32'(w0));
    chk("other_busy", 32'(busy), 0);

    // Form feed
    attr = 8'h55;
    w0 = n_writes;
    send_w(8'h0C);
    chk_cursor("ff_cursor", 0, 0);
    chk("ff_writes", 32'(n_writes), 32'(w0 + 2400));
    chk("ff_last", 32'(last_addr), 2399);
    chk("ff_queue_empty", 32'(exp_q.size()), 0);

    // Reset in the middle of a row clear (after 40 words)
    attr = 8'h07;
    send(8'h0A);
    begin
      int n = 0;
      while (!(ram_we && ram_addr == 12'd119) && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reached_40", 32'(ram_we && ram_addr == 12'd119), 1);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("abort_we", 32'(ram_we), 0);
    chk("abort_addr", 32'(ram_addr), 0);
    chk("abort_busy", 32'(busy), 1);
    chk("abort_ready", 32'(ch_ready), 0);
    chk("abort_queue_left", 32'(exp_q.size()), 40);
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    push_clear_all();
    w0 = n_writes;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_we", 32'(ram_we), 1);
    chk("restart_addr", 32'(ram_addr), 0);
    wait_ready();
    chk("restart_writes", 32'(n_writes), 32'(w0 + 2400));
    chk("restart_queue_empty", 32'(exp_q.size()), 0);
    chk_cursor("restart_cursor", 0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameters SHALL be: COLS, 80, text columns; ROWS, 30, text rows; BLANK, 8'h20, fill character code.
REQ-002 Ports SHALL be (name direction width meaning):
  clk  input  1  single system clock, all logic on rising edge
  rst  input  1  asynchronous, active-low reset
  ch_valid  input  1  character byte offered
  ch_data  input  8  character/control code
  ch_ready  output  1  block accepts ch_data this cycle
  attr  input  8  colour attribute, sampled per write
  ram_addr  output  12  text RAM write address (row*COLS+col)
  ram_data  output  16  {attr, char code}
  ram_we  output  1  text RAM write strobe, one word per high cycle
  cursor_col  output  7  current column, 0..COLS-1
  cursor_row  output  5  current row, 0..ROWS-1
  busy  output  1  high whenever state is not IDLE
REQ-003 Clock is clk; reset is rst, asynchronous and active-low; no other clock or reset exists.
REQ-004 All outputs SHALL be driven from registers.

Function
REQ-005 States SHALL be IDLE, WRITE, CLR_ROW, CLR_ALL.
REQ-006 ch_ready SHALL be 1 only in IDLE; transfer occurs on a rising edge with ch_valid=1 and ch_ready=1.
REQ-007 ch_valid while ch_ready=0 SHALL be ignored; the source holds ch_data stable until transfer.
REQ-008 Printable code (0x20..0x7E) SHALL go IDLE->WRITE; in WRITE, ram_we=1 for exactly one cycle with ram_addr=cursor position at transfer, ram_data={attr,code}.
REQ-009 After a printable write, col SHALL increment; if col was COLS-1, col->0, row advances (REQ-013) and state goes to CLR_ROW, else back to IDLE.
REQ-010 0x0A (LF) SHALL set col=0, advance row, enter CLR_ROW; no character write.
REQ-011 0x0D (CR) SHALL set col=0, return to IDLE with no write.
REQ-012 0x08 (BS): col>0 -> col-1, then WRITE of {attr,BLANK} at the new position; col=0 -> no change, no write.
REQ-013 Row advance SHALL wrap ROWS-1 -> 0; no scrolling.
REQ-014 CLR_ROW SHALL issue COLS consecutive ram_we cycles, addresses row*COLS+0..COLS-1 ascending, data {attr,BLANK}, then IDLE; cursor stays at (0,row).
REQ-015 0x0C (FF) SHALL enter CLR_ALL: ROWS*COLS consecutive ram_we cycles, addresses 0..ROWS*COLS-1 ascending, data {attr,BLANK}; cursor set to (0,0); then IDLE.
REQ-016 Any other code (0x00..0x1F not listed, 0x7F..0xFF) SHALL be consumed with no write and no cursor change; state stays IDLE.
REQ-017 ram_addr SHALL be computed as row*COLS+col in 12 bits; it never exceeds ROWS*COLS-1 (2399 at defaults).
REQ-018 ram_we SHALL be 0 in IDLE; ram_addr/ram_data hold last values when ram_we=0.
REQ-019 busy SHALL equal (state != IDLE).

Reset
REQ-020 While rst=0: ram_we=0, ram_addr=0, ram_data=0, cursor=(0,0), ch_ready=0, busy=1, state=CLR_ALL, clear counter=0.
REQ-021 After rst release the block SHALL perform a full CLR_ALL (REQ-015), first write at address 0 on the first rising edge after release.
REQ-022 rst asserted mid-operation SHALL abort the sequence immediately (ram_we=0 asynchronously) and restart per REQ-021 on release.

Verification
REQ-023 Reset release, attr=0x07 -> 2400 writes addr 0..2399 data 0x0720, then ch_ready=1, cursor (0,0).
REQ-024 From (0,0), send 'A'(0x41) attr=0x1E -> one cycle ram_we, addr 0, data 0x1E41; cursor (1,0); ch_ready back high after 2 cycles.
REQ-025 Cursor (79,5), send 'Z' -> write addr 479; cursor (0,6); 80 writes addr 480..559 data {attr,0x20}.
REQ-026 Cursor (10,29), send 0x0A -> cursor (0,0); 80 writes addr 0..79; then 0x0D at (3,0) -> cursor (0,0), no write.
REQ-027 Cursor (5,2), send 0x08 -> cursor (4,2), one write addr 164 data {attr,0x20}; at (0,2) 0x08 -> no write; 0x01 -> no write, no cursor change.
REQ-028 Assert rst during CLR_ROW at count 40 -> ram_we drops immediately; after release full 2400-word clear from addr 0.
